// File: rtl/pll_lock_reset_seq_if.sv
// pll_lock_reset_seq_if: lock, request and status signals between the rPLL reset sequencer and its neighbours
`timescale 1ns/1ps
interface pll_lock_reset_seq_if #(
   parameter int LOSS_CNT_W = 8
);
   logic                  pll_lock;
   logic                  soft_rst_req;
   logic                  clear_sticky;
   logic                  sys_rst_n;
   logic                  clk_ready;
   logic                  lock_lost_sticky;
   logic [LOSS_CNT_W-1:0] lock_loss_count;
   logic [1:0]            seq_state;
   modport master (
      output pll_lock, soft_rst_req, clear_sticky,
      input  sys_rst_n, clk_ready, lock_lost_sticky, lock_loss_count, seq_state
   );
   modport slave (
      input  pll_lock, soft_rst_req, clear_sticky,
      output sys_rst_n, clk_ready, lock_lost_sticky, lock_loss_count, seq_state
   );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: waits for a stable rPLL lock, then releases the NPU system reset and tracks lock losses
`timescale 1ns/1ps
module pll_lock_reset_seq #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   pll_lock_reset_seq_if.slave bus
);
   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD_RST, RUN} state_t;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic                   clk_ready_q, clk_ready_d;
   logic                   sticky_q, sticky_d;
   logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
   logic                   lock_s;
   logic                   loss;
   assign lock_s = sync_q[SYNC_STAGES-1];
   // next-state logic: a lock drop before RUN just restarts; a drop in RUN is a recorded loss that beats soft reset
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
      state_d = state_q;
      cnt_d   = cnt_q;
      loss    = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end
         end
         STABILIZE: begin
            if (!lock_s) state_d = WAIT_LOCK;
            else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = HOLD_RST;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         HOLD_RST: begin
            if (!lock_s) state_d = WAIT_LOCK;
            else if (cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         default: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               loss    = 1'b1;
            end else if (bus.soft_rst_req) begin
               state_d = HOLD_RST;
               cnt_d   = '0;
            end
         end
      endcase
      sys_rst_n_d = (state_d == RUN);
      clk_ready_d = (state_d == RUN);
      sticky_d    = loss | (sticky_q & ~bus.clear_sticky);
      loss_cnt_d  = (loss && loss_cnt_q != '1) ? loss_cnt_q + LOSS_CNT_W'(1) : loss_cnt_q;
   end
   // every flop, including the outputs, updates on the same edge as the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         sys_rst_n_q <= 1'b0;
         clk_ready_q <= 1'b0;
         sticky_q    <= 1'b0;
         loss_cnt_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_rst_n_q <= sys_rst_n_d;
         clk_ready_q <= clk_ready_d;
         sticky_q    <= sticky_d;
         loss_cnt_q  <= loss_cnt_d;
      end
   end
   assign bus.sys_rst_n        = sys_rst_n_q;
   assign bus.clk_ready        = clk_ready_q;
   assign bus.lock_lost_sticky = sticky_q;
   assign bus.lock_loss_count  = loss_cnt_q;
   assign bus.seq_state        = state_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: directed and random checks of the lock/reset sequencer against a timeline model
`timescale 1ns/1ps
module tb_pll_lock_reset_seq;
   localparam int SYNC = 2;
   localparam int L    = 8;
   localparam int H    = 4;
   localparam int W    = 2;
   localparam int CMAX = (1 << W) - 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   pll_lock_reset_seq_if #(.LOSS_CNT_W(W)) bus ();
   pll_lock_reset_seq #(
      .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(L), .RESET_HOLD_CYCLES(H), .LOSS_CNT_W(W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   always #10.582 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // model: m_el counts edges since the sequence left WAIT_LOCK; the phase follows from it arithmetically
   bit m_act = 0;
   int m_el = 0;
   bit m_sticky = 0;
   int m_cnt = 0;
   bit sh [SYNC];
   bit m_ls;
   int m_st;
   function automatic int m_state();
      return !m_act ? 0 : (m_el < L) ? 1 : (m_el < L + H) ? 2 : 3;
   endfunction
   initial begin
      foreach (sh[i]) sh[i] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_act = 0; m_el = 0; m_sticky = 0; m_cnt = 0;
            foreach (sh[i]) sh[i] = 0;
         end else begin
            m_ls = sh[SYNC-1];
            m_st = m_state();
            if (bus.clear_sticky) m_sticky = 0;
            if (m_st == 3 && !m_ls) begin
               m_sticky = 1;
               m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            end
            if (!m_act) begin
               if (m_ls) begin m_act = 1; m_el = 0; end
            end else if (!m_ls) m_act = 0;
            else if (m_st == 3) begin
               if (bus.soft_rst_req) m_el = L;
            end else m_el++;
            for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = bus.pll_lock;
         end
      end
   end
   // per-cycle comparison against the model, away from the active edge
   int cst;
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         cst = m_state();
         chk("model sys_rst_n", int'(bus.sys_rst_n), int'(cst == 3));
         chk("model clk_ready", int'(bus.clk_ready), int'(cst == 3));
         chk("model seq_state", int'(bus.seq_state), cst);
         chk("model sticky", int'(bus.lock_lost_sticky), int'(m_sticky));
         chk("model loss_count", int'(bus.lock_loss_count), m_cnt);
      end
   end
   // raise pll_lock now (just after an edge) and pin the 15-edge path to RUN
   task automatic seq15(input string tag);
      bus.pll_lock = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         chk({tag, " sys_rst_n"}, int'(bus.sys_rst_n), int'(n == 15));
         chk({tag, " seq_state"}, int'(bus.seq_state), n < 3 ? 0 : n < 11 ? 1 : n < 15 ? 2 : 3);
      end
      chk({tag, " clk_ready"}, int'(bus.clk_ready), 1);
   endtask
   initial begin
      bus.pll_lock = 1'b0;
      bus.soft_rst_req = 1'b0;
      bus.clear_sticky = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("por sys_rst_n", int'(bus.sys_rst_n), 0);
      end
      #1 rst_n = 1'b1;
      @(posedge clk); #2;
      seq15("powerup");
      @(posedge clk); #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2 bus.pll_lock = 1'b1;
      repeat (5) @(posedge clk);
      #2 bus.pll_lock = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("glitch state", int'(bus.seq_state), 0);
      chk("glitch sticky", int'(bus.lock_lost_sticky), 0);
      chk("glitch count", int'(bus.lock_loss_count), 0);
      seq15("glitch");
      for (int i = 1; i <= 4; i++) begin
         #1 bus.pll_lock = 1'b0;
         for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            chk("loss sys_rst_n", int'(bus.sys_rst_n), int'(n < 3));
         end
         chk("loss sticky", int'(bus.lock_lost_sticky), 1);
         chk("loss count", int'(bus.lock_loss_count), i < 3 ? i : 3);
         chk("loss state", int'(bus.seq_state), 0);
         seq15("relock");
      end
      #1 bus.soft_rst_req = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk); #1;
         bus.soft_rst_req = 1'b0;
         chk("soft sys_rst_n", int'(bus.sys_rst_n), int'(n == 5));
      end
      chk("soft count", int'(bus.lock_loss_count), 3);
      #1 bus.soft_rst_req = 1'b1;
      @(posedge clk); #1;
      bus.soft_rst_req = 1'b0;
      chk("hold state", int'(bus.seq_state), 2);
      @(posedge clk); #4 rst_n = 1'b0;
      #1;
      chk("async sys_rst_n", int'(bus.sys_rst_n), 0);
      chk("async clk_ready", int'(bus.clk_ready), 0);
      chk("async state", int'(bus.seq_state), 0);
      chk("async sticky", int'(bus.lock_lost_sticky), 0);
      chk("async count", int'(bus.lock_loss_count), 0);
      @(posedge clk); #2 rst_n = 1'b1;
      seq15("after_async");
      #1 bus.pll_lock = 1'b0;
      repeat (2) @(posedge clk);
      #2 begin bus.soft_rst_req = 1'b1; bus.clear_sticky = 1'b1; end
      @(posedge clk); #1;
      bus.soft_rst_req = 1'b0;
      bus.clear_sticky = 1'b0;
      chk("simul state", int'(bus.seq_state), 0);
      chk("simul count", int'(bus.lock_loss_count), 1);
      chk("simul sticky", int'(bus.lock_lost_sticky), 1);
      chk("simul sys_rst_n", int'(bus.sys_rst_n), 0);
      bus.clear_sticky = 1'b1;
      @(posedge clk); #1;
      bus.clear_sticky = 1'b0;
      chk("clear sticky", int'(bus.lock_lost_sticky), 0);
      chk("clear count", int'(bus.lock_loss_count), 1);
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         if (bus.pll_lock) bus.pll_lock = ($urandom_range(0, 39) != 0);
         else bus.pll_lock = ($urandom_range(0, 3) == 0);
         bus.soft_rst_req = ($urandom_range(0, 9) == 0);
         bus.clear_sticky = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 799) == 0) begin
            #3 rst_n = 1'b0;
            @(posedge clk); #2 rst_n = 1'b1;
         end
      end
      @(posedge clk); #2;
      bus.soft_rst_req = 1'b0;
      bus.clear_sticky = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
- Sits directly downstream of the Gowin rPLL and runs in the PLL output clock domain.
- Synchronises the asynchronous PLL lock flag and requires it to stay stable for a set time before doing anything else.
- Drives the synchronous-deassert system reset for the NPU core and reports loss-of-lock events to status logic.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the lock synchroniser (minimum 2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before leaving reset.
- RESET_HOLD_CYCLES, 16: cycles sys_rst_n stays low after stable lock, and after a soft reset request.
- LOSS_CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk  input  1  PLL output clock (rPLL clkout).
- rst_n  input  1  asynchronous active-low reset.
- pll_lock  input  1  rPLL lock flag, asynchronous to clk.
- soft_rst_req  input  1  single-cycle request to re-run the reset hold from RUN.
- clear_sticky  input  1  clears lock_lost_sticky.
- sys_rst_n  output  1  registered active-low system reset, deasserted synchronously.
- clk_ready  output  1  high only in RUN.
- lock_lost_sticky  output  1  set when lock drops while in RUN.
- lock_loss_count  output  LOSS_CNT_W  saturating count of lock losses from RUN.
- seq_state  output  2  current FSM state: 0 WAIT_LOCK, 1 STABILIZE, 2 HOLD_RST, 3 RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all sync flops 0, seq_state=WAIT_LOCK, counter 0, sys_rst_n=0, clk_ready=0, lock_lost_sticky=0, lock_loss_count=0.
- Reset assertion forces these values immediately, with no clock needed. This applies mid-sequence too.
- Synchroniser: a SYNC_STAGES-deep chain gives lock_s. The FSM only ever uses lock_s.
- All outputs are registered and change on the same edge as the state transition they belong to.
- WAIT_LOCK:
  - sys_rst_n=0.
  - If lock_s=1, go to STABILIZE and clear the counter.
- STABILIZE:
  - If lock_s=0, go back to WAIT_LOCK. This is a glitch restart: the counter is discarded and no loss is recorded.
  - Otherwise the counter increments.
  - When the counter equals LOCK_STABLE_CYCLES-1, go to HOLD_RST and clear the counter.
  - The state therefore lasts exactly LOCK_STABLE_CYCLES cycles.
- HOLD_RST:
  - sys_rst_n=0.
  - If lock_s=0, go to WAIT_LOCK with no loss recorded.
  - Otherwise count RESET_HOLD_CYCLES cycles, then go to RUN, setting sys_rst_n=1 and clk_ready=1.
- RUN:
  - If lock_s=0: go to WAIT_LOCK, sys_rst_n=0 and clk_ready=0 on the next edge, lock_lost_sticky=1, lock_loss_count increments and saturates at all-ones.
  - Else if soft_rst_req=1: go to HOLD_RST, sys_rst_n=0, clk_ready=0, counter cleared, no loss recorded.
- Simultaneous events:
  - Lock loss beats soft_rst_req.
  - Setting lock_lost_sticky beats clear_sticky in the same cycle.
  - soft_rst_req is ignored outside RUN.
- Latency from a clean pll_lock rise to sys_rst_n=1 is SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES clk edges. With defaults this is 1043.
- Latency from pll_lock fall in RUN to sys_rst_n=0 is SYNC_STAGES+1 edges.
- Counter width is clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)). It never wraps, because it is cleared on every transition.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, LOSS_CNT_W=2, clk 21.164 ns):
- Power-up:
  - Stimulus: rst_n low for 5 cycles, pll_lock rises 2 ns after an edge and stays high, rst_n released before the rise.
  - Required: sys_rst_n=0 throughout, then sys_rst_n=1 and clk_ready=1 exactly 15 edges after the first edge sampling pll_lock=1. seq_state steps 0→1→2→3.
- Lock glitch in STABILIZE:
  - Stimulus: pll_lock high 5 cycles, low 3, then high.
  - Required: seq_state returns to 0, lock_lost_sticky=0, count=0. The full 15-edge sequence restarts from the second rise.
- Lock loss in RUN, repeated 4 times:
  - Required: sys_rst_n=0 three edges after each fall, lock_lost_sticky=1, lock_loss_count goes 1,2,3,3 (saturation). Each relock returns to RUN.
- Soft reset:
  - Stimulus: soft_rst_req pulse in RUN.
  - Required: sys_rst_n low for exactly 4 cycles, then high. lock_loss_count unchanged.
- Simultaneous events:
  - Stimulus: soft_rst_req in the same cycle lock_s falls, plus clear_sticky in that cycle.
  - Required: state goes to WAIT_LOCK, count increments, lock_lost_sticky=1.
  - Then clear_sticky alone → lock_lost_sticky=0.
- Async reset mid-HOLD_RST:
  - Stimulus: rst_n asserted between clock edges.
  - Required: all outputs reach reset values before the next edge. After release with pll_lock high, the full 15-edge sequence runs again.
